mux4_rr_arbiter: RTL

Round-robin arbiter and sequencer that shares a single 4:1 multiplexed output channel between four requesters. Each requester presents valid/data/last beats; the block picks one requester, steers its data through the 4:1 select, and holds the selection until that requester's packet ends. The result goes into a one-stage registered output with valid/ready flow control. It sits between up to four packet sources and one downstream consumer.

---
 rtl/mux4_rr_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one registered 4:1 output channel among four packet sources.
// Ownership is held from a packet's first beat until its last beat transfers.
module mux4_rr_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   in_valid,
    input  logic [W-1:0] in_data0,
    input  logic [W-1:0] in_data1,
    input  logic [W-1:0] in_data2,
    input  logic [W-1:0] in_data3,
    input  logic [3:0]   in_last,
    output logic [3:0]   in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic [1:0]   out_src,
    input  logic         out_ready,
    output logic         busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [1:0]   r_ptr;
    logic [1:0]   r_owner;
    logic [1:0]   w_ptr_nxt;
    logic [1:0]   w_owner_nxt;
    logic [1:0]   w_pick;
    logic [1:0]   w_src;
    logic         w_any;
    logic         w_can_accept;
    logic         w_xfer;
    logic         w_last_sel;
    logic [3:0]   w_ready;
    logic [W-1:0] w_data_sel;

    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    logic         r_out_last;
    logic [1:0]   r_out_src;

    // Scan from the highest offset down so the requester nearest ptr wins.
    always_comb begin
        w_pick = r_ptr;
        w_any  = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (in_valid[r_ptr + 2'(k)]) begin
                w_pick = r_ptr + 2'(k);
                w_any  = 1'b1;
            end
        end
    end

    assign w_can_accept = !r_out_valid || out_ready;
    assign w_src        = (r_state == ST_LOCK) ? r_owner : w_pick;

    // Ready is gated by rst_n so nothing is accepted while reset is asserted.
    always_comb begin
        w_ready = 4'b0000;
        if (rst_n) begin
            if (r_state == ST_LOCK) begin
                w_ready[r_owner] = w_can_accept;
            end else if (w_any) begin
                w_ready[w_pick] = w_can_accept;
            end
        end
    end

    always_comb begin
        case (w_src)
            2'd0:    w_data_sel = in_data0;
            2'd1:    w_data_sel = in_data1;
            2'd2:    w_data_sel = in_data2;
            default: w_data_sel = in_data3;
        endcase
    end

    assign w_last_sel = in_last[w_src];
    assign w_xfer     = in_valid[w_src] && w_ready[w_src];

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        if (w_xfer) begin
            if (w_last_sel) begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = w_src + 2'd1;
            end else begin
                w_state_nxt = ST_LOCK;
                w_owner_nxt = w_src;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 2'd0;
            r_owner     <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_data_sel;
                r_out_last  <= w_last_sel;
                r_out_src   <= w_src;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_src   = r_out_src;
    assign busy      = (r_state == ST_LOCK);

endmodule
